// File: rtl/lc3b_types.sv
// Types shared by the LC-3b memory subsystem blocks.
package lc3b_types;

  localparam int MEM_ADDR_W = 20;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_CPU,
    OWNER_DBG
  } mem_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single asynchronous SRAM port.
// CPU datapath and debug/loader share the part; each access is a fixed
// SETUP / ACCESS(W) / DONE sequence ending in a one-cycle ack to the owner.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | controls released; the only state where requests are sampled
// SETUP  | chip selected, address settled; read enables OE, write drives bus
// ACCESS | WAIT_CYCLES cycles; WE strobes low for writes; read data
//        | captured on the final edge
// DONE   | controls released, owner acked, write data held one more cycle
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic              busy,
  output logic              grant_dbg
);

  // Wait-state count is 1..15, so a 4-bit down-counter covers it.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  mem_arb_state_t    state_q, state_d;
  // Owner of the current transaction doubles as the round-robin pointer.
  mem_owner_t        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  // Next-state: arbitration in IDLE, wait-state countdown, read capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          if (cpu_req && dbg_req) begin
            owner_d = (owner_q == OWNER_DBG) ? OWNER_CPU : OWNER_DBG;
          end else begin
            owner_d = dbg_req ? OWNER_DBG : OWNER_CPU;
          end
          if (owner_d == OWNER_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WAIT_LD;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWNER_DBG) begin
              dbg_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // SRAM strobes decoded from the registered state; OE and WE are never low together.
  always_comb begin
    CE          = 1'b1;
    UB          = 1'b1;
    LB          = 1'b1;
    OE          = 1'b1;
    WE          = 1'b1;
    mem_data_oe = 1'b0;
    case (state_q)
      SETUP, ACCESS: begin
        CE          = 1'b0;
        UB          = 1'b0;
        LB          = 1'b0;
        OE          = we_q;
        WE          = !(we_q && (state_q == ACCESS));
        mem_data_oe = we_q;
      end
      DONE: begin
        // Keep driving write data one cycle past the WE rising edge for hold.
        mem_data_oe = we_q;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ack   = (state_q == DONE) && (owner_q == OWNER_CPU);
  assign dbg_ack   = (state_q == DONE) && (owner_q == OWNER_DBG);
  assign busy      = (state_q != IDLE);
  assign grant_dbg = (owner_q == OWNER_DBG);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: one W=2 instance checked every cycle against a
// timeline model, plus W=1 and W=15 instances exercised with directed reads.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int MAIN_W = 2;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [19:0] cpu_addr, dbg_addr, mem_addr;
  logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic [15:0] mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_data_oe;
  logic        CE, UB, LB, OE, WE, busy, grant_dbg;

  logic [15:0] sram [256];
  logic        init_mem;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  function automatic logic [15:0] mem_init(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    edge_n++;
  end

  mem_arbiter #(.WAIT_CYCLES(MAIN_W)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_rdata(mem_rdata),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .busy(busy), .grant_dbg(grant_dbg)
  );

  // SRAM behaviour: asynchronous read, write while CE and WE are both low.
  always_comb mem_rdata = sram[mem_addr[7:0]];

  always @(posedge Clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) sram[i] <= mem_init(i);
    end else if (!CE && !WE) begin
      sram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Extra builds with the shortest and longest wait-state settings (read-only users).
  logic        aux_req   [2];
  logic [19:0] aux_addr  [2];
  logic        aux_ack   [2];
  logic [15:0] aux_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_aux
    logic [19:0] ma;
    logic [15:0] mw, mr, drd;
    logic        moe, ce, ub, lb, oe, we, bsy, gd, dack;
    always_comb mr = sram[ma[7:0]];
    mem_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 15)) u_aux (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(aux_req[g]), .cpu_we(1'b0), .cpu_addr(aux_addr[g]), .cpu_wdata(16'h0000),
      .cpu_rdata(aux_rdata[g]), .cpu_ack(aux_ack[g]),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h00000), .dbg_wdata(16'h0000),
      .dbg_rdata(drd), .dbg_ack(dack),
      .mem_addr(ma), .mem_wdata(mw), .mem_data_oe(moe), .mem_rdata(mr),
      .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
      .busy(bsy), .grant_dbg(gd)
    );
  end

  // ---------------- behavioural model of the W=2 instance ----------------
  // A transaction granted at edge t0 occupies the cycles after edges
  // t0 .. t0+W+1: offset 0 is setup, 1..W are the access wait states,
  // W+1 is the ack cycle. The port is free again from edge t0+W+3.
  int          m_cyc = 0;
  int          m_t0 = 0;
  bit          m_on = 0;
  bit          m_active = 0;
  bit          m_own = 1;
  bit          m_last = 1;
  bit          m_we = 0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_cpu_rd = '0;
  logic [15:0] m_dbg_rd = '0;
  logic [15:0] mm [256];

  initial forever begin
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      m_active = 0;
      m_last   = 1;
      m_own    = 1;
      m_we     = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_cpu_rd = '0;
      m_dbg_rd = '0;
      if (init_mem) for (int i = 0; i < 256; i++) mm[i] = mem_init(i);
    end else begin : model_edge
      bit was_idle;
      m_on = 1;
      m_cyc++;
      was_idle = !m_active;
      if (m_active && m_cyc == m_t0 + MAIN_W + 2) m_active = 0;
      if (was_idle && (cpu_req || dbg_req)) begin
        m_own    = (cpu_req && dbg_req) ? !m_last : dbg_req;
        m_last   = m_own;
        m_we     = m_own ? dbg_we : cpu_we;
        m_addr   = m_own ? dbg_addr : cpu_addr;
        m_wdata  = m_own ? dbg_wdata : cpu_wdata;
        m_t0     = m_cyc;
        m_active = 1;
      end
      if (m_active && m_cyc == m_t0 + MAIN_W + 1) begin
        if (m_we) mm[m_addr[7:0]] = m_wdata;
        else if (m_own) m_dbg_rd = mm[m_addr[7:0]];
        else m_cpu_rd = mm[m_addr[7:0]];
      end
    end
  end

  // Per-cycle compare of every main-instance output against the model.
  initial forever begin
    @(negedge Clk);
    if (Reset && m_on) begin : cmp
      int k;
      bit sel;
      k   = m_cyc - m_t0;
      sel = m_active && (k <= MAIN_W);
      chk("busy", 32'(busy), 32'(m_active));
      chk("CE", 32'(CE), 32'(!sel));
      chk("UB", 32'(UB), 32'(!sel));
      chk("LB", 32'(LB), 32'(!sel));
      chk("OE", 32'(OE), 32'(!(sel && !m_we)));
      chk("WE", 32'(WE), 32'(!(m_active && m_we && k >= 1 && k <= MAIN_W)));
      chk("mem_data_oe", 32'(mem_data_oe), 32'(m_active && m_we));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_active && k == MAIN_W + 1 && !m_own));
      chk("dbg_ack", 32'(dbg_ack), 32'(m_active && k == MAIN_W + 1 && m_own));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("grant_dbg", 32'(grant_dbg), 32'(m_last));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
      chk("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rd));
    end
  end

  // Strobe activity counters used by the directed checks.
  int ce_low = 0, oe_low = 0, we_low = 0, doe_high = 0;
  initial forever begin
    @(negedge Clk);
    if (!CE) ce_low++;
    if (!OE) oe_low++;
    if (!WE) we_low++;
    if (mem_data_oe) doe_high++;
  end

  // Call at posedge+1 with the arbiter idle; returns at posedge+1 after the ack cycle.
  task automatic main_txn(input bit dbg, input bit we, input logic [19:0] a,
                          input logic [15:0] wd, output int lat, output logic [15:0] rd);
    int n;
    n = 0;
    if (dbg) begin
      dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    end
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!(dbg ? dbg_ack : cpu_ack) && n < 40);
    lat = n;
    rd  = dbg ? dbg_rdata : cpu_rdata;
    @(posedge Clk); #1;
    if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    chk("ack_single_cycle", 32'(dbg ? dbg_ack : cpu_ack), 32'd0);
  endtask

  task automatic aux_read(input int i, input logic [19:0] a, input logic [15:0] exp_d,
                          input int exp_lat);
    int n;
    n = 0;
    aux_addr[i] = a;
    aux_req[i]  = 1'b1;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!aux_ack[i] && n < 40);
    chk($sformatf("aux%0d_latency", i), 32'(n), 32'(exp_lat));
    chk($sformatf("aux%0d_rdata", i), 32'(aux_rdata[i]), 32'(exp_d));
    @(posedge Clk); #1;
    aux_req[i] = 1'b0;
    chk($sformatf("aux%0d_ack_single", i), 32'(aux_ack[i]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, r, acks, busy_n;
    int          e_ack [4];
    bit          who [4];
    int          c0, o0, w0, d0;
    logic [15:0] rd;

    Reset    = 1'b0;
    init_mem = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      aux_req[i]  = 1'b0;
      aux_addr[i] = '0;
    end
    repeat (3) @(posedge Clk);
    #1 init_mem = 1'b0;

    // Reset values
    chk("rst_CE", 32'(CE), 32'd1);
    chk("rst_UB", 32'(UB), 32'd1);
    chk("rst_LB", 32'(LB), 32'd1);
    chk("rst_OE", 32'(OE), 32'd1);
    chk("rst_WE", 32'(WE), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    chk("rst_data_oe", 32'(mem_data_oe), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Both ports requesting out of reset: CPU first, then strict alternation.
    cpu_we = 1'b0; cpu_addr = 20'h00010;
    dbg_we = 1'b0; dbg_addr = 20'h00020;
    cpu_req = 1'b1; dbg_req = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    r = edge_n;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(posedge Clk); #1;
        lat++;
      end while (!cpu_ack && !dbg_ack && lat < 20);
      chk("alt_wait", 32'(lat < 20), 32'd1);
      who[i]   = dbg_ack;
      e_ack[i] = edge_n;
    end
    @(posedge Clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("alt_first_latency", 32'(e_ack[0] - r), 32'd4);
    chk("alt_order", 32'({who[0], who[1], who[2], who[3]}), 32'b0101);
    for (int i = 1; i < 4; i++) chk("alt_spacing", 32'(e_ack[i] - e_ack[i-1]), 32'd5);

    // CPU read of preloaded word.
    c0 = ce_low; o0 = oe_low; w0 = we_low; d0 = doe_high;
    main_txn(1'b0, 1'b0, 20'h00010, 16'h0000, lat, rd);
    chk("cpu_rd_latency", 32'(lat), 32'd4);
    chk("cpu_rd_data", 32'(rd), 32'h1234);
    chk("cpu_rd_ce_cycles", 32'(ce_low - c0), 32'd3);
    chk("cpu_rd_oe_cycles", 32'(oe_low - o0), 32'd3);
    chk("cpu_rd_we_cycles", 32'(we_low - w0), 32'd0);
    chk("cpu_rd_doe_cycles", 32'(doe_high - d0), 32'd0);

    // Debug write, then read back through the CPU port.
    c0 = ce_low; o0 = oe_low; w0 = we_low; d0 = doe_high;
    main_txn(1'b1, 1'b1, 20'h00020, 16'hBEEF, lat, rd);
    chk("dbg_wr_latency", 32'(lat), 32'd4);
    chk("dbg_wr_we_cycles", 32'(we_low - w0), 32'd2);
    chk("dbg_wr_doe_cycles", 32'(doe_high - d0), 32'd4);
    chk("dbg_wr_oe_cycles", 32'(oe_low - o0), 32'd0);
    chk("dbg_wr_ce_cycles", 32'(ce_low - c0), 32'd3);
    main_txn(1'b0, 1'b0, 20'h00020, 16'h0000, lat, rd);
    chk("cpu_readback", 32'(rd), 32'hBEEF);

    // CPU write, debug read-back; CPU read data must be untouched by either.
    main_txn(1'b0, 1'b1, 20'h00030, 16'h55AA, lat, rd);
    chk("cpu_wr_keeps_rdata", 32'(cpu_rdata), 32'hBEEF);
    main_txn(1'b1, 1'b0, 20'h00030, 16'h0000, lat, rd);
    chk("dbg_readback", 32'(rd), 32'h55AA);
    chk("dbg_rd_keeps_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

    // Request withdrawn during SETUP still completes exactly once.
    cpu_we = 1'b0; cpu_addr = 20'h00010; cpu_req = 1'b1;
    @(posedge Clk); #1;
    cpu_req = 1'b0;
    busy_n = busy ? 1 : 0;
    acks = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (cpu_ack) acks++;
      if (busy) busy_n++;
    end
    chk("drop_acks", 32'(acks), 32'd1);
    chk("drop_busy_cycles", 32'(busy_n), 32'd4);
    chk("drop_rdata", 32'(cpu_rdata), 32'h1234);

    // Reset in the middle of an access aborts it without an ack.
    cpu_we = 1'b0; cpu_addr = 20'h00020; cpu_req = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_OE", 32'(OE), 32'd0);
    #1 Reset = 1'b0;
    #1;
    cpu_req = 1'b0;
    chk("abort_controls", 32'({CE, UB, LB, OE, WE}), 32'b11111);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    chk("abort_data_oe", 32'(mem_data_oe), 32'd0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    acks = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (cpu_ack || dbg_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);

    // Shortest and longest wait-state builds.
    aux_read(0, 20'h00010, 16'h1234, 3);
    aux_read(1, 20'h00010, 16'h1234, 17);
    aux_read(1, 20'h00020, 16'hBEEF, 17);
    aux_read(0, 20'h00030, 16'h55AA, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
